// File: rtl/riscv_pkg.sv
// Shared constants for the memory stage and its memory-mapped peripherals.
//   MTIME_ADDR_DEFAULT / MTIMECMP_ADDR_DEFAULT : default timer register bases
//   store_size_e                               : store-size encoding (byte/half/word/double)
//   store_byte_mask()                          : right-aligned byte-lane mask for a store size
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NBYTES = XLEN / 8;

    localparam logic [63:0] MTIME_ADDR_DEFAULT    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] MTIMECMP_ADDR_DEFAULT = 64'h0000_0000_0200_4000;

    typedef enum logic [1:0] {
        STORE_B = 2'b00,
        STORE_H = 2'b01,
        STORE_W = 2'b10,
        STORE_D = 2'b11
    } store_size_e;

    // Lanes touched by a store of the given size, before shifting to the offset.
    function automatic logic [NBYTES-1:0] store_byte_mask(input store_size_e size);
        logic [NBYTES-1:0] mask;
        case (size)
            STORE_B: mask = 8'h01;
            STORE_H: mask = 8'h03;
            STORE_W: mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/riscv_mtimer_wmerge.sv
// Merges a right-aligned store into a 64-bit register image.
//   old_i       : current register value
//   wdata_i     : store data, byte 0 in bits 7:0
//   storesize_i : store_size_e encoding
//   off_i       : starting byte lane
//   merged_o    : value after the store (lanes past 7 are dropped, no wrap)
module riscv_mtimer_wmerge
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [1:0]      storesize_i,
    input  logic [2:0]      off_i,
    output logic [XLEN-1:0] merged_o
);

    logic [NBYTES-1:0] lane_mask;
    logic [XLEN-1:0]   bit_mask;
    logic [XLEN-1:0]   shifted;

    // Shifting the 8-bit mask discards lanes beyond 7 naturally.
    assign lane_mask = store_byte_mask(store_size_e'(storesize_i)) << off_i;
    assign shifted   = wdata_i << {off_i, 3'b000};

    // Expand per-lane enables into a per-bit mask.
    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
    end

    assign merged_o = (old_i & ~bit_mask) | (shifted & bit_mask);

endmodule

// File: rtl/riscv_mtimer.sv
// Memory-mapped RISC-V machine timer (mtime / mtimecmp) for the memory stage.
//   i_riscv_mtimer_clk/rst   : clock, async active-high reset
//   i_riscv_mtimer_addr      : memory-stage byte address
//   i_riscv_mtimer_wdata     : right-aligned store data
//   i_riscv_mtimer_storesize : store_size_e encoding
//   i_riscv_mtimer_wren/rden : store / load valid
//   i_riscv_mtimer_stall     : blocks writes; time keeps running
//   o_riscv_mtimer_rdata     : full selected register on a load hit, else 0
//   o_riscv_mtimer_rden      : load hit on mtime or mtimecmp
//   o_riscv_mtimer_irq       : registered machine timer interrupt request
// Build option: RISCV_MTIMER_PRESCALER_EN advances mtime once every PRESCALE cycles.
module riscv_mtimer
    import riscv_pkg::*;
#(
    parameter logic [63:0] MTIME_ADDR    = MTIME_ADDR_DEFAULT,
    parameter logic [63:0] MTIMECMP_ADDR = MTIMECMP_ADDR_DEFAULT,
    parameter int unsigned PRESCALE      = 16
) (
    input  logic            i_riscv_mtimer_clk,
    input  logic            i_riscv_mtimer_rst,
    input  logic [XLEN-1:0] i_riscv_mtimer_addr,
    input  logic [XLEN-1:0] i_riscv_mtimer_wdata,
    input  logic [1:0]      i_riscv_mtimer_storesize,
    input  logic            i_riscv_mtimer_wren,
    input  logic            i_riscv_mtimer_rden,
    input  logic            i_riscv_mtimer_stall,
    output logic [XLEN-1:0] o_riscv_mtimer_rdata,
    output logic            o_riscv_mtimer_rden,
    output logic            o_riscv_mtimer_irq
);

    if (PRESCALE == 0) begin : g_bad_prescale
        $error("riscv_mtimer: PRESCALE must be >= 1");
    end

    logic [XLEN-1:0] mtime_q, mtime_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic            irq_q, irq_d;
    logic [XLEN-1:0] mtime_merged, mtimecmp_merged;
    logic            hit_time, hit_cmp;
    logic            wr_ok, wr_time, wr_cmp;
    logic            tick;
    logic [2:0]      off;

    // Address decode on the 8-byte register granule.
    assign hit_time = (i_riscv_mtimer_addr[XLEN-1:3] == MTIME_ADDR[XLEN-1:3]);
    assign hit_cmp  = (i_riscv_mtimer_addr[XLEN-1:3] == MTIMECMP_ADDR[XLEN-1:3]);
    assign off      = i_riscv_mtimer_addr[2:0];

    assign wr_ok   = i_riscv_mtimer_wren & ~i_riscv_mtimer_stall;
    assign wr_time = wr_ok & hit_time;
    assign wr_cmp  = wr_ok & hit_cmp;

    // Read path is combinational from state so a same-cycle store reads the old value.
    assign o_riscv_mtimer_rden  = i_riscv_mtimer_rden & (hit_time | hit_cmp);
    assign o_riscv_mtimer_rdata = !o_riscv_mtimer_rden ? '0 :
                                  hit_time             ? mtime_q : mtimecmp_q;
    assign o_riscv_mtimer_irq   = irq_q;

    riscv_mtimer_wmerge u_wmerge_time (
        .old_i       (mtime_q),
        .wdata_i     (i_riscv_mtimer_wdata),
        .storesize_i (i_riscv_mtimer_storesize),
        .off_i       (off),
        .merged_o    (mtime_merged)
    );

    riscv_mtimer_wmerge u_wmerge_cmp (
        .old_i       (mtimecmp_q),
        .wdata_i     (i_riscv_mtimer_wdata),
        .storesize_i (i_riscv_mtimer_storesize),
        .off_i       (off),
        .merged_o    (mtimecmp_merged)
    );

`ifdef RISCV_MTIMER_PRESCALER_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == PS_W'(PRESCALE - 1));

    // Prescale counter restarts on wrap and on any software write to mtime.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_time || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PS_W'(1);
        end
    end

    always_ff @(posedge i_riscv_mtimer_clk or posedge i_riscv_mtimer_rst) begin
        if (i_riscv_mtimer_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Next state: software write beats the tick; mtimecmp only moves on writes.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_time) begin
            mtime_d = mtime_merged;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr_cmp) begin
            mtimecmp_d = mtimecmp_merged;
        end
        irq_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge i_riscv_mtimer_clk or posedge i_riscv_mtimer_rst) begin
        if (i_riscv_mtimer_rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_riscv_mtimer.sv
// Self-checking bench for riscv_mtimer: directed scenarios plus randomized
// traffic compared against a byte-level behavioural model of the timer.
module tb_riscv_mtimer;

    localparam logic [63:0] A_TIME = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] A_CMP  = 64'h0000_0000_0200_4000;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int unsigned PS     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  sz = '0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic        stall = 1'b0;
    logic [63:0] o_rdata;
    logic        o_rden;
    logic        o_irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_time = '0;
    logic [63:0] m_cmp  = ONES;
    logic        m_irq  = 1'b0;
`ifdef RISCV_MTIMER_PRESCALER_EN
    int unsigned m_cnt  = 0;
`endif
    logic [63:0] last_rdata;

    riscv_mtimer #(.PRESCALE(PS)) dut (
        .i_riscv_mtimer_clk       (clk),
        .i_riscv_mtimer_rst       (rst),
        .i_riscv_mtimer_addr      (addr),
        .i_riscv_mtimer_wdata     (wdata),
        .i_riscv_mtimer_storesize (sz),
        .i_riscv_mtimer_wren      (wren),
        .i_riscv_mtimer_rden      (rden),
        .i_riscv_mtimer_stall     (stall),
        .o_riscv_mtimer_rdata     (o_rdata),
        .o_riscv_mtimer_rden      (o_rden),
        .o_riscv_mtimer_irq       (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Store written byte-by-byte: n bytes landing at off, off+1, ... while < 8.
    function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic [63:0] d,
                                              input logic [1:0] size, input int off);
        logic [63:0] r = old;
        int n = 1 << size;
        for (int k = 0; k < n; k++) begin
            if (off + k < 8) r[(off + k)*8 +: 8] = d[k*8 +: 8];
        end
        return r;
    endfunction

    function automatic bit is_time(input logic [63:0] a);
        return (a >> 3) == (A_TIME >> 3);
    endfunction

    function automatic bit is_cmp(input logic [63:0] a);
        return (a >> 3) == (A_CMP >> 3);
    endfunction

    task automatic model_reset();
        m_time = '0;
        m_cmp  = ONES;
        m_irq  = 1'b0;
`ifdef RISCV_MTIMER_PRESCALER_EN
        m_cnt  = 0;
`endif
    endtask

    task automatic model_edge();
        logic [63:0] tn = m_time;
        logic [63:0] cn = m_cmp;
        bit wr  = wren && !stall;
        bit tck;
        int off = int'(addr % 64'd8);
`ifdef RISCV_MTIMER_PRESCALER_EN
        tck = (m_cnt == PS - 1);
`else
        tck = 1'b1;
`endif
        if (wr && is_cmp(addr)) cn = ref_merge(m_cmp, wdata, sz, off);
        if (wr && is_time(addr)) begin
            tn = ref_merge(m_time, wdata, sz, off);
`ifdef RISCV_MTIMER_PRESCALER_EN
            m_cnt = 0;
`endif
        end else begin
            if (tck) tn = m_time + 64'd1;
`ifdef RISCV_MTIMER_PRESCALER_EN
            m_cnt = (m_cnt + 1) % PS;
`endif
        end
        m_time = tn;
        m_cmp  = cn;
        m_irq  = (tn >= cn);
    endtask

    // One clock: drive, check read path before the edge, advance model, check irq.
    task automatic cycle(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                         input logic we, input logic re, input logic st);
        logic        e_rden;
        logic [63:0] e_rdata;
        addr = a; wdata = d; sz = s; wren = we; rden = re; stall = st;
        #1;
        e_rden  = re && (is_time(a) || is_cmp(a));
        e_rdata = !e_rden ? 64'd0 : (is_time(a) ? m_time : m_cmp);
        last_rdata = o_rdata;
        check("rden", {63'd0, o_rden}, {63'd0, e_rden});
        check("rdata", o_rdata, e_rdata);
        @(posedge clk);
        model_edge();
        #1;
        check("irq", {63'd0, o_irq}, {63'd0, m_irq});
    endtask

    task automatic idle();
        cycle(64'd0, 64'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [63:0] a);
        cycle(a, 64'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic st(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
        cycle(a, d, s, 1'b1, 1'b0, 1'b0);
    endtask

    // Async reset in mid-cycle with a store pending; called at posedge+1.
    task automatic mid_reset();
        addr = A_TIME; wdata = 64'h1234; sz = 2'b11; wren = 1'b1; rden = 1'b1; stall = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_time", o_rdata, 64'd0);
        check("rst_rden", {63'd0, o_rden}, 64'd1);
        check("rst_irq", {63'd0, o_irq}, 64'd0);
        addr = A_CMP;
        #1;
        check("rst_cmp", o_rdata, ONES);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wren = 1'b0;
    endtask

    initial begin
        logic [63:0] steps [8];
        steps[0] = 64'd0; steps[1] = 64'd0; steps[2] = 64'd0; steps[3] = 64'd1;
        steps[4] = 64'd1; steps[5] = 64'd1; steps[6] = 64'd1; steps[7] = 64'd2;

        // Reset state
        #1 rst = 1'b1;
        addr = A_TIME; rden = 1'b1;
        #1;
        check("reset_time", o_rdata, 64'd0);
        check("reset_irq", {63'd0, o_irq}, 64'd0);
        addr = A_CMP;
        #1;
        check("reset_cmp", o_rdata, ONES);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Free-running count and decode
        repeat (10) idle();
        rd(A_TIME);
`ifndef RISCV_MTIMER_PRESCALER_EN
        check("mtime_10", last_rdata, 64'd10);
`endif
        rd(64'h0000_0000_8000_0000);
        check("nohit_rdata", last_rdata, 64'd0);

        // Compare match and clear
        st(A_CMP, 64'h20, 2'b11);
        for (int n = 0; n < 400 && !m_irq; n++) idle();
        check("irq_set", {63'd0, o_irq}, 64'd1);
        st(A_CMP, 64'h1000, 2'b11);
        check("irq_clr", {63'd0, o_irq}, 64'd0);

        // Byte store into lane 3 of mtime, no increment that cycle
        st(A_TIME, 64'd0, 2'b11);
        st(64'h0200_BFFB, 64'hAB, 2'b00);
        rd(A_TIME);
        check("byte_store", last_rdata, 64'h0000_0000_AB00_0000);

        // Word store at offset 6 keeps only lanes 6..7
        st(A_CMP, ONES, 2'b11);
        st(64'h0200_4006, 64'h1122_3344, 2'b10);
        rd(A_CMP);
        check("word_clip", last_rdata, 64'h3344_FFFF_FFFF_FFFF);

        // mtime wrap
        st(A_TIME, ONES, 2'b11);
        rd(A_TIME);
        check("wrap_pre", last_rdata, ONES);
        rd(A_TIME);
`ifndef RISCV_MTIMER_PRESCALER_EN
        check("wrap_post", last_rdata, 64'd0);
`endif

        // Stalled store is dropped
        cycle(A_CMP, 64'h55, 2'b11, 1'b1, 1'b0, 1'b1);
        rd(A_CMP);
        check("stall_cmp", last_rdata, 64'h3344_FFFF_FFFF_FFFF);

        // Same-cycle read and write returns the old value
        cycle(A_CMP, 64'h77, 2'b11, 1'b1, 1'b1, 1'b0);
        check("rw_old", last_rdata, 64'h3344_FFFF_FFFF_FFFF);

        // Reset mid-count, then prescaled stepping
        mid_reset();
        idle();
`ifdef RISCV_MTIMER_PRESCALER_EN
        for (int i = 0; i < 8; i++) begin
            rd(A_TIME);
            check("prescale_step", last_rdata, steps[i]);
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [63:0] a, d;
            int sel = int'($urandom_range(0, 4));
            a = (sel == 0) ? A_TIME + 64'($urandom_range(0, 7)) :
                (sel == 1) ? A_CMP + 64'($urandom_range(0, 7)) :
                (sel == 2) ? A_CMP :
                (sel == 3) ? {$urandom, $urandom} : A_TIME;
            d = ($urandom_range(0, 1) == 1) ? m_time + 64'($urandom_range(0, 40))
                                            : {$urandom, $urandom};
            if (i % 150 == 149) mid_reset();
            cycle(a, d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
